// File: rtl/npc_pkg.sv
// Shared NPC core definitions: CSR indices, ebreak encoding, mstatus field
// positions and the writeback FSM state type.
package npc_pkg;

    localparam int NUM_GPR = 32;
    localparam int NUM_CSR = 4;

    localparam logic [1:0] CSR_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_MTVEC   = 2'd1;
    localparam logic [1:0] CSR_MEPC    = 2'd2;
    localparam logic [1:0] CSR_MCAUSE  = 2'd3;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_csr_unit.sv
// Machine CSR block (mstatus, mtvec, mepc, mcause) merging software CSR
// writes with trap side effects; trap updates override overlapping writes.
module wb_csr_unit
    import npc_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 64'h0000_000A_0000_1800
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            accept,
    input  logic [XLEN-1:0]                 pc,
    input  logic                            csr_wen,
    input  logic [1:0]                      csr_idx,
    input  logic [XLEN-1:0]                 csr_data,
    input  logic                            trap,
    input  logic [XLEN-1:0]                 trap_cause,
    output logic [NUM_CSR-1:0][XLEN-1:0]    csr_q
);

    logic [NUM_CSR-1:0][XLEN-1:0] csr_d;

    always_comb begin
        csr_d = csr_q;
        if (accept && csr_wen) begin
            csr_d[csr_idx] = csr_data;
        end
        // MPIE takes MIE as it was before this instruction retired.
        if (accept && trap) begin
            csr_d[CSR_MEPC]                                   = pc;
            csr_d[CSR_MCAUSE]                                 = trap_cause;
            csr_d[CSR_MSTATUS][MSTATUS_MPIE]                  = csr_q[CSR_MSTATUS][MSTATUS_MIE];
            csr_d[CSR_MSTATUS][MSTATUS_MIE]                   = 1'b0;
            csr_d[CSR_MSTATUS][MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q[CSR_MSTATUS] <= MSTATUS_RST;
            csr_q[CSR_MTVEC]   <= '0;
            csr_q[CSR_MEPC]    <= '0;
            csr_q[CSR_MCAUSE]  <= '0;
        end else begin
            csr_q <= csr_d;
        end
    end

endmodule

// File: rtl/wb_commit_regfile.sv
// Writeback/commit stage: GPR file with decode bypass, CSR update, ebreak halt
// and commit trace. Optional retire counter enabled by WB_INSTRET_EN.
module wb_commit_regfile
    import npc_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 64'h0000_000A_0000_1800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [XLEN-1:0]             wb_pc,
    input  logic [31:0]                 wb_inst,
    input  logic                        wb_rd_wen,
    input  logic [4:0]                  wb_rd,
    input  logic [XLEN-1:0]             wb_rd_data,
    input  logic                        wb_csr_wen,
    input  logic [1:0]                  wb_csr_idx,
    input  logic [XLEN-1:0]             wb_csr_data,
    input  logic                        wb_trap,
    input  logic [XLEN-1:0]             wb_trap_cause,
    input  logic [4:0]                  rs1_addr,
    input  logic [4:0]                  rs2_addr,
    output logic [XLEN-1:0]             rs1_data,
    output logic [XLEN-1:0]             rs2_data,
    output logic [NUM_GPR*XLEN-1:0]     trace_gpr,
    output logic [NUM_CSR*XLEN-1:0]     trace_csr,
    output logic [XLEN-1:0]             trace_pc,
    output logic                        commit_valid,
    output logic                        halt,
    output logic [XLEN-1:0]             halt_code,
    output logic [XLEN-1:0]             instret
);

    wb_state_e                      state_q;
    wb_state_e                      state_d;
    logic                           accept;
    logic                           is_ebreak;
    logic                           gpr_wen;
    logic [XLEN-1:0]                a0_after;
    logic [NUM_GPR-1:0][XLEN-1:0]   gpr;
    logic [NUM_CSR-1:0][XLEN-1:0]   csr_q;

    assign accept    = wb_valid && wb_ready;
    assign is_ebreak = (wb_inst == INST_EBREAK);
    assign gpr_wen   = accept && wb_rd_wen && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_RUN:  if (accept && is_ebreak) state_d = WB_HALT;
            WB_HALT: state_d = WB_HALT;
            default: state_d = WB_RUN;
        endcase
    end

    always_comb begin
        wb_ready = 1'b0;
        halt     = 1'b0;
        case (state_q)
            WB_RUN:  wb_ready = 1'b1;
            WB_HALT: halt     = 1'b1;
            default: wb_ready = 1'b0;
        endcase
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr <= '0;
        end else if (gpr_wen) begin
            gpr[wb_rd] <= wb_rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0)                 ? '0 :
                      (gpr_wen && (wb_rd == rs1_addr))   ? wb_rd_data :
                                                           gpr[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                 ? '0 :
                      (gpr_wen && (wb_rd == rs2_addr))   ? wb_rd_data :
                                                           gpr[rs2_addr];

    assign a0_after = (gpr_wen && (wb_rd == 5'd10)) ? wb_rd_data : gpr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_pc     <= '0;
            commit_valid <= 1'b0;
            halt_code    <= '0;
        end else begin
            commit_valid <= accept;
            if (accept) begin
                trace_pc <= wb_pc;
            end
            if (accept && is_ebreak) begin
                halt_code <= a0_after;
            end
        end
    end

    wb_csr_unit #(
        .XLEN        (XLEN),
        .MSTATUS_RST (MSTATUS_RST)
    ) u_csr (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .pc         (wb_pc),
        .csr_wen    (wb_csr_wen),
        .csr_idx    (wb_csr_idx),
        .csr_data   (wb_csr_data),
        .trap       (wb_trap),
        .trap_cause (wb_trap_cause),
        .csr_q      (csr_q)
    );

    assign trace_gpr = gpr;
    assign trace_csr = csr_q;

`ifdef WB_INSTRET_EN
    logic [XLEN-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (accept) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Directed self-checking bench for wb_commit_regfile.
module tb_wb_commit_regfile;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wb_valid;
    logic           wb_ready;
    logic [63:0]    wb_pc;
    logic [31:0]    wb_inst;
    logic           wb_rd_wen;
    logic [4:0]     wb_rd;
    logic [63:0]    wb_rd_data;
    logic           wb_csr_wen;
    logic [1:0]     wb_csr_idx;
    logic [63:0]    wb_csr_data;
    logic           wb_trap;
    logic [63:0]    wb_trap_cause;
    logic [4:0]     rs1_addr;
    logic [4:0]     rs2_addr;
    logic [63:0]    rs1_data;
    logic [63:0]    rs2_data;
    logic [2047:0]  trace_gpr;
    logic [255:0]   trace_csr;
    logic [63:0]    trace_pc;
    logic           commit_valid;
    logic           halt;
    logic [63:0]    halt_code;
    logic [63:0]    instret;

    int total = 0;
    int bad   = 0;

`ifdef WB_INSTRET_EN
    localparam logic [63:0] EXP_INSTRET_5 = 64'd5;
`else
    localparam logic [63:0] EXP_INSTRET_5 = 64'd0;
`endif
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    always #5 clk = ~clk;

    wb_commit_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_pc         (wb_pc),
        .wb_inst       (wb_inst),
        .wb_rd_wen     (wb_rd_wen),
        .wb_rd         (wb_rd),
        .wb_rd_data    (wb_rd_data),
        .wb_csr_wen    (wb_csr_wen),
        .wb_csr_idx    (wb_csr_idx),
        .wb_csr_data   (wb_csr_data),
        .wb_trap       (wb_trap),
        .wb_trap_cause (wb_trap_cause),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .trace_gpr     (trace_gpr),
        .trace_csr     (trace_csr),
        .trace_pc      (trace_pc),
        .commit_valid  (commit_valid),
        .halt          (halt),
        .halt_code     (halt_code),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_pc = '0; wb_inst = NOP;
        wb_rd_wen = 0; wb_rd = '0; wb_rd_data = '0;
        wb_csr_wen = 0; wb_csr_idx = '0; wb_csr_data = '0;
        wb_trap = 0; wb_trap_cause = '0;
    endtask

    task automatic set_inst(input logic [63:0] pc, input logic [31:0] inst,
                            input logic rd_wen, input logic [4:0] rd, input logic [63:0] rd_data);
        clear_inputs();
        wb_valid = 1; wb_pc = pc; wb_inst = inst;
        wb_rd_wen = rd_wen; wb_rd = rd; wb_rd_data = rd_data;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rs1_addr = '0; rs2_addr = '0;
        rst_n = 0;
        #12;

        for (int i = 0; i < 32; i++) check($sformatf("rst_gpr%0d", i), trace_gpr[i*64 +: 64], 64'd0);
        check("rst_mstatus", trace_csr[63:0], 64'h0000_000A_0000_1800);
        check("rst_mepc", trace_csr[191:128], 64'd0);
        check("rst_pc", trace_pc, 64'd0);
        check("rst_ready", {63'd0, wb_ready}, 64'd1);
        check("rst_cv", {63'd0, commit_valid}, 64'd0);
        check("rst_halt", {63'd0, halt}, 64'd0);

        @(negedge clk); rst_n = 1;

        // x5 <- DEAD_BEEF
        @(negedge clk);
        set_inst(64'h8000_0000, NOP, 1, 5'd5, 64'hDEAD_BEEF);
        edge_settle(); clear_inputs();
        check("x5_val", trace_gpr[383:320], 64'hDEAD_BEEF);
        check("x5_pc", trace_pc, 64'h8000_0000);
        check("x5_cv", {63'd0, commit_valid}, 64'd1);
        edge_settle();
        check("idle_cv", {63'd0, commit_valid}, 64'd0);
        check("idle_pc_hold", trace_pc, 64'h8000_0000);

        // write to x0 is discarded
        @(negedge clk);
        set_inst(64'h8000_0004, NOP, 1, 5'd0, 64'hFFFF);
        rs1_addr = 5'd0;
        #1 check("x0_rd_bypass", rs1_data, 64'd0);
        edge_settle(); clear_inputs();
        check("x0_trace", trace_gpr[63:0], 64'd0);
        check("x0_pc", trace_pc, 64'h8000_0004);

        // no bypass without valid
        @(negedge clk);
        clear_inputs(); wb_rd_wen = 1; wb_rd = 5'd7; wb_rd_data = 64'h1234;
        rs1_addr = 5'd7;
        #1 check("nobypass_novalid", rs1_data, 64'd0);

        // same-cycle bypass to both read ports
        set_inst(64'h8000_0008, NOP, 1, 5'd7, 64'h1234);
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        #1;
        check("bypass_rs1", rs1_data, 64'h1234);
        check("rs2_stored", rs2_data, 64'hDEAD_BEEF);
        edge_settle(); clear_inputs();
        check("x7_trace", trace_gpr[7*64 +: 64], 64'h1234);
        check("x7_read", rs1_data, 64'h1234);

        // set MIE through a CSR write
        @(negedge clk);
        set_inst(64'h8000_000C, NOP, 0, 5'd0, 64'd0);
        wb_csr_wen = 1; wb_csr_idx = 2'd0; wb_csr_data = 64'h0000_000A_0000_1808;
        edge_settle(); clear_inputs();
        check("mstatus_wr", trace_csr[63:0], 64'h0000_000A_0000_1808);

        // trap beats the simultaneous mepc write
        @(negedge clk);
        set_inst(64'h8000_0010, NOP, 0, 5'd0, 64'd0);
        wb_csr_wen = 1; wb_csr_idx = 2'd2; wb_csr_data = 64'h55;
        wb_trap = 1; wb_trap_cause = 64'd11;
        edge_settle(); clear_inputs();
        check("trap_mepc", trace_csr[191:128], 64'h8000_0010);
        check("trap_mcause", trace_csr[255:192], 64'd11);
        check("trap_mstatus", trace_csr[63:0], 64'h0000_000A_0000_1880);
        check("trap_mtvec", trace_csr[127:64], 64'd0);

        // fresh reset, four back-to-back commits, then ebreak with a0 <- 0
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        set_inst(64'h8000_0014, NOP, 1, 5'd10, 64'h99);
        edge_settle();
        check("b2b_a0", trace_gpr[10*64 +: 64], 64'h99);
        set_inst(64'h8000_0018, NOP, 1, 5'd1, 64'h1);
        edge_settle();
        check("b2b_cv1", {63'd0, commit_valid}, 64'd1);
        set_inst(64'h8000_001C, NOP, 1, 5'd2, 64'h2);
        edge_settle();
        set_inst(64'h8000_0020, NOP, 1, 5'd3, 64'h3);
        edge_settle();
        check("b2b_cv3", {63'd0, commit_valid}, 64'd1);
        check("b2b_x3", trace_gpr[3*64 +: 64], 64'h3);
        set_inst(64'h8000_0024, EBREAK, 1, 5'd10, 64'h0);
        edge_settle();
        check("halt", {63'd0, halt}, 64'd1);
        check("halt_code", halt_code, 64'd0);
        check("halt_ready", {63'd0, wb_ready}, 64'd0);
        check("halt_pc", trace_pc, 64'h8000_0024);
        check("instret", instret, EXP_INSTRET_5);

        // valid ignored while halted
        set_inst(64'h9000_0000, NOP, 1, 5'd11, 64'h77);
        rs1_addr = 5'd11;
        #1 check("halt_nobypass", rs1_data, 64'd0);
        edge_settle();
        edge_settle();
        check("halt_cv", {63'd0, commit_valid}, 64'd0);
        check("halt_pc_hold", trace_pc, 64'h8000_0024);
        check("halt_x11", trace_gpr[11*64 +: 64], 64'd0);
        check("halt_instret", instret, EXP_INSTRET_5);
        check("halt_stays", {63'd0, halt}, 64'd1);
        clear_inputs();

        // reset releases halt; then drop an in-flight instruction with reset
        @(negedge clk); rst_n = 0;
        #1 check("rst_halt_clr", {63'd0, halt}, 64'd0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        set_inst(64'hA000_0000, NOP, 1, 5'd6, 64'h1);
        edge_settle();
        check("pre_drop_pc", trace_pc, 64'hA000_0000);
        set_inst(64'hB000_0000, NOP, 1, 5'd6, 64'h2);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("drop_pc", trace_pc, 64'd0);
        check("drop_cv", {63'd0, commit_valid}, 64'd0);
        check("drop_x6", trace_gpr[6*64 +: 64], 64'd0);
        edge_settle();
        clear_inputs();
        @(negedge clk); rst_n = 1;
        edge_settle();
        check("drop_pc_after", trace_pc, 64'd0);
        check("drop_cv_after", {63'd0, commit_valid}, 64'd0);
        check("drop_ready", {63'd0, wb_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_commit_regfile.md
# wb_commit_regfile

Writeback/commit stage of the NPC core: accepts retiring instructions from MEM over a valid/ready handshake, updates the 32×64 GPR file and four machine CSRs, and halts on `ebreak`. It serves decode's two read ports with writeback bypass. It drives the committed architectural state (GPRs, CSRs, PC) and a one-cycle commit strobe to the downstream difftest trace stage, which exports them over DPI.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `MSTATUS_RST`, 64'h0000_000A_0000_1800, reset value of mstatus

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `wb_valid`  in  1  MEM presents a retiring instruction
- `wb_ready`  out  1  stage accepts this cycle
- `wb_pc`  in  64  PC of retiring instruction
- `wb_inst`  in  32  instruction word
- `wb_rd_wen` / `wb_rd` / `wb_rd_data`  in  1/5/64  GPR write
- `wb_csr_wen` / `wb_csr_idx` / `wb_csr_data`  in  1/2/64  CSR write (0 mstatus, 1 mtvec, 2 mepc, 3 mcause)
- `wb_trap` / `wb_trap_cause`  in  1/64  instruction takes a trap
- `rs1_addr`, `rs2_addr`  in  5  decode read addresses
- `rs1_data`, `rs2_data`  out  64  decode read data (combinational)
- `trace_gpr`  out  2048  GPR *i* at bits [64i+63:64i]
- `trace_csr`  out  256  CSR *k* at bits [64k+63:64k]
- `trace_pc`  out  64  PC of last committed instruction
- `commit_valid`  out  1  one-cycle pulse per commit
- `halt` / `halt_code`  out  1/64  ebreak seen; a0 value at halt
- `instret`  out  64  retired-instruction count

## Operation
- FSM states RUN and HALT. Reset enters RUN. `wb_ready = (state == RUN)`.
- Accept = `wb_valid && wb_ready`. On an accept edge:
  - GPR write when `wb_rd_wen && wb_rd != 0`; x0 is always read and traced as 0.
  - CSR write when `wb_csr_wen`.
  - On `wb_trap`: mepc←`wb_pc`; mcause←`wb_trap_cause`; mstatus.MPIE←MIE; MIE←0; MPP←2'b11. Where trap and CSR write target the same CSR field, the trap wins. Other fields keep the written value.
  - `trace_pc`←`wb_pc`; `commit_valid`←1.
- If `wb_inst == 32'h0010_0073` (ebreak) is accepted, the FSM goes to HALT. `halt_code` captures a0 as it stands after this instruction's own write, including any bypassed value. The ebreak itself counts as committed.
- In HALT, `wb_ready` = 0 and `wb_valid` is ignored. Only reset leaves HALT.
- Read ports return the GPR value. If an accept in the same cycle writes the addressed register (nonzero), the port returns `wb_rd_data`. Address 0 returns 0.
- No accept in a cycle: `commit_valid` = 0 in the next cycle and all state holds.

## Timing
- Reset values (immediate, asynchronous): all GPRs 0; mstatus = `MSTATUS_RST`; mtvec, mepc, mcause 0; `trace_pc` 0; `commit_valid` 0; `halt` 0; `halt_code` 0; `instret` 0; state RUN.
- Commit latency is 1 cycle: updated state appears on trace outputs and `commit_valid` in the cycle after the accept edge.
- Back-to-back accepts are allowed every cycle; `commit_valid` then stays high.
- `wb_ready` is driven from registered state only; no combinational path from `wb_valid`.
- Reset asserted mid-handshake drops the in-flight instruction; there is no partial commit.
- `instret` increments once per accept and wraps modulo 2^64.

## Configuration
- `WB_INSTRET_EN` defined: the 64-bit retire counter is implemented and drives `instret`.
- Not defined: no counter flops; `instret` is tied to 0.

## Structure
- Shared package `npc_pkg` holds:
  - CSR index constants `CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MEPC`, `CSR_MCAUSE`
  - `INST_EBREAK`
  - mstatus field bit positions (MIE 3, MPIE 7, MPP 12:11)
  - state enum `wb_state_e`
- One sub-module, `wb_csr_unit`, contains the four CSRs with the write/trap merge logic. It takes accept, trap, and CSR-write inputs and outputs 4×64 values.

## Test plan
- Reset, then check: every `trace_gpr` slice 0, mstatus slice = 64'hA_0000_1800, `trace_pc` 0, `wb_ready` 1.
- Accept x5←64'hDEAD_BEEF at pc 64'h8000_0000 → next cycle bits [383:320] = DEAD_BEEF, `trace_pc` = 8000_0000, one-cycle `commit_valid`. Repeat with rd=0 → x0 stays 0.
- Same cycle: accept x7←64'h1234 with `rs1_addr`=7 → `rs1_data` = 64'h1234 combinationally, before the edge.
- Trap with cause 11 at pc 64'h8000_0010, MIE=1, plus `wb_csr_wen` to mepc=0x55 → mepc = 8000_0010, mcause = 11, MIE 0, MPIE 1, MPP 3.
- Four back-to-back accepts, then a0←0 with ebreak → `halt`=1, `halt_code`=0, `wb_ready`=0, `instret`=5. Further `wb_valid` changes nothing.
- Assert `rst_n` low while `wb_valid` is high mid-stream → outputs clear immediately and the dropped instruction never appears on `trace_pc`.
